// File: rtl/sdc_response_reader.sv
// Receives a 48-bit SD command response from the serial CMD line, checks its
// CRC7 and framing bits, and reports completion or a start-bit timeout.
module sdc_response_reader #(
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_in,
  input  logic        sample_en,
  input  logic        arm,
  input  logic        skip_crc,
  output logic [47:0] response,
  output logic        resp_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  localparam int WW = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, CHECK} state_t;

  state_t        state;
  logic [47:0]   shift_reg;
  logic [5:0]    bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [6:0]    crc_reg;
  logic          skip_reg;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      crc_reg    <= '0;
      skip_reg   <= 1'b0;
      response   <= '0;
      resp_valid <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // A strobe coinciding with arm is deliberately not sampled.
          if (arm) begin
            state     <= WAIT_START;
            busy      <= 1'b1;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            crc_reg   <= '0;
            shift_reg <= '0;
            skip_reg  <= skip_crc;
          end
        end
        WAIT_START: begin
          if (sample_en) begin
            if (!cmd_in) begin
              shift_reg <= {shift_reg[46:0], 1'b0};
              bit_cnt   <= 6'd1;
              crc_reg   <= crc7_step(crc_reg, 1'b0);
              state     <= RECEIVE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              if (wait_cnt == WW'(NCR_MAX - 1)) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        RECEIVE: begin
          if (bit_cnt == 6'd48) begin
            state <= CHECK;
          end else if (sample_en) begin
            shift_reg <= {shift_reg[46:0], cmd_in};
            bit_cnt   <= bit_cnt + 6'd1;
            // CRC covers bits 47..8; bit_cnt 1..39 maps to bits 46..8.
            if (bit_cnt < 6'd40) begin
              crc_reg <= crc7_step(crc_reg, cmd_in);
            end
          end
        end
        CHECK: begin
          response   <= shift_reg;
          crc_err    <= !skip_reg && (crc_reg != shift_reg[7:1]);
          frame_err  <= shift_reg[46] | ~shift_reg[0];
          resp_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_response_reader.sv
// Directed bench for sdc_response_reader: table of known frames plus
// hand-written timeout, reset and re-arm sequences.
module tb_sdc_response_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_in = 1'b1;
  logic        sample_en = 1'b0;
  logic        arm = 1'b0;
  logic        skip_crc = 1'b0;
  logic [47:0] response;
  logic        resp_valid;
  logic        crc_err;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  sdc_response_reader #(.NCR_MAX(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_in     (cmd_in),
    .sample_en  (sample_en),
    .arm        (arm),
    .skip_crc   (skip_crc),
    .response   (response),
    .resp_valid (resp_valid),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] frame;
    logic        skip;
    logic        exp_crc;
    logic        exp_fe;
    int          gap;
    int          idle;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv_count = 0;
  int rv_cyc = 0;
  int tmo_count = 0;
  int tmo_cyc = 0;
  int both_count = 0;
  int k_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      rv_count <= rv_count + 1;
      rv_cyc   <= cyc;
    end
    if (timeout) begin
      tmo_count <= tmo_count + 1;
      tmo_cyc   <= cyc;
    end
    if (resp_valid && timeout) both_count <= both_count + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic strobe(input logic b, input int gap, input logic arm_here);
    cmd_in    = b;
    sample_en = 1'b1;
    arm       = arm_here;
    if (arm_here) skip_crc = ~skip_crc;
    @(negedge clk);
    sample_en = 1'b0;
    if (arm_here) skip_crc = ~skip_crc;
    arm    = 1'b0;
    cmd_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic arm_pulse(input logic s, input logic with_strobe);
    arm       = 1'b1;
    skip_crc  = s;
    sample_en = with_strobe;
    cmd_in    = ~with_strobe;
    @(negedge clk);
    arm       = 1'b0;
    sample_en = 1'b0;
    cmd_in    = 1'b1;
  endtask

  task automatic send_bits(input logic [47:0] f, input int gap, input int arm_idx, input int last);
    for (int i = 47; i >= last; i--) begin
      strobe(f[i], (i == 0) ? 0 : gap, (i == arm_idx));
      if (i == 0) k_cyc = cyc;
    end
  endtask

  task automatic run_frame(input string tag, input vec_t v, input int arm_idx, input logic arm_strobe);
    int rv0, t0;
    rv0 = rv_count;
    t0  = tmo_count;
    arm_pulse(v.skip, arm_strobe);
    chk({tag, "_busy_armed"}, busy, 1);
    chk({tag, "_flags_cleared"}, {crc_err, frame_err}, 2'b00);
    for (int j = 0; j < v.idle; j++) strobe(1'b1, v.gap, 1'b0);
    send_bits(v.frame, v.gap, arm_idx, 0);
    repeat (5) @(negedge clk);
    chk({tag, "_rv_count"}, rv_count - rv0, 1);
    chk({tag, "_latency"}, rv_cyc - k_cyc, 2);
    chk({tag, "_response"}, response, v.frame);
    chk({tag, "_crc_err"}, crc_err, v.exp_crc);
    chk({tag, "_frame_err"}, frame_err, v.exp_fe);
    chk({tag, "_no_timeout"}, tmo_count - t0, 0);
    chk({tag, "_busy_done"}, busy, 0);
    $display("frame %s: response=%012h crc_err=%0b frame_err=%0b", tag, response, crc_err, frame_err);
  endtask

  initial begin
    int rv0, t0;
    logic [47:0] prev;
    vec_t v;

    vecs[0] = '{48'h400000000095, 1'b0, 1'b0, 1'b1, 0, 3};
    vecs[1] = '{48'h400000000097, 1'b0, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{48'h3F80FF8000FF, 1'b1, 1'b0, 1'b0, 2, 5};
    vecs[3] = '{48'h48000001AA87, 1'b0, 1'b0, 1'b1, 0, 1};
    vecs[4] = '{48'h770000000065, 1'b0, 1'b0, 1'b1, 1, 2};
    vecs[5] = '{48'h400000000094, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{48'h400000000097, 1'b1, 1'b0, 1'b1, 0, 1};
    vecs[7] = '{48'h3F80FF8000FE, 1'b1, 1'b0, 1'b1, 1, 0};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_response", response, 48'h0);
    chk("reset_flags", {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);

    for (int n = 0; n < 8; n++) begin
      run_frame($sformatf("vec%0d", n), vecs[n], -1, 1'b0);
    end

    // Start-bit timeout: 63 idle strobes are tolerated, the 64th expires.
    prev = response;
    t0   = tmo_count;
    rv0  = rv_count;
    arm_pulse(1'b0, 1'b0);
    for (int j = 0; j < 63; j++) strobe(1'b1, 0, 1'b0);
    chk("tmo_early", tmo_count - t0, 0);
    chk("tmo_busy_waiting", busy, 1);
    strobe(1'b1, 0, 1'b0);
    k_cyc = cyc;
    chk("tmo_pulse_now", timeout, 1);
    chk("tmo_busy_after", busy, 0);
    strobe(1'b0, 0, 1'b0);
    chk("tmo_single_pulse", tmo_count - t0, 1);
    chk("tmo_clk", tmo_cyc - k_cyc, 0);
    chk("tmo_response_kept", response, prev);
    chk("tmo_no_rv", rv_count - rv0, 0);
    $display("timeout: tmo_count=%0d busy=%0b response=%012h", tmo_count - t0, busy, response);

    // Asynchronous reset mid-frame.
    arm_pulse(1'b0, 1'b0);
    send_bits(48'h400000000097, 0, -1, 28);
    chk("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_response", response, 48'h0);
    chk("midrst_flags", {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    rv0 = rv_count;
    t0  = tmo_count;
    for (int j = 0; j < 70; j++) strobe(j[0], 0, 1'b0);
    chk("postrst_idle_busy", busy, 0);
    chk("postrst_idle_rv", rv_count - rv0, 0);
    chk("postrst_idle_tmo", tmo_count - t0, 0);
    $display("reset: response=%012h busy=%0b", response, busy);
    run_frame("rearm", vecs[3], -1, 1'b0);

    // A low strobe coinciding with arm must not be taken as the start bit.
    v = '{48'h400000000097, 1'b0, 1'b1, 1'b1, 0, 0};
    run_frame("arm_with_strobe", v, -1, 1'b1);

    // Slow strobes with a second arm mid-frame that tries to flip skip_crc.
    v = '{48'h400000000097, 1'b0, 1'b1, 1'b1, 3, 2};
    run_frame("midarm", v, 20, 1'b0);

    chk("never_rv_and_timeout", both_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
